ttt_packet_frontend: RTL and testbench
======================================

# ttt_packet_frontend

Parametrised I/O front-end for the tick-tock-tokens core. It sits between the chip pins and the main core, reassembling opcode/data packets that arrive over an input bus of configurable width across several beats, and decoding them into the core's field signals behind a valid/ready handshake. It also buffers the start/stop events emitted by the core in a FIFO, so that a slow external reader does not lose events. Sticky flags report reserved opcodes and FIFO overflow.

## Interface
Parameters:
- NUM_PROCESSORS, 15: processor count; PROC_BITS = $clog2(NUM_PROCESSORS)
- NUM_CONNECTIONS, 225: connection count; CONN_BITS = $clog2(NUM_CONNECTIONS)
- NEW_TOKEN_BITS, 4: width of the token-weight field
- TOKEN_BITS, 8: width of the threshold field
- DURATION_BITS, 8: width of the duration field
- IN_WIDTH, 8: input beat width
- FIFO_DEPTH, 4: event FIFO depth; must be a power of 2, minimum 2

Derived:
- DATA_BITS = max(PROC_BITS+2·NEW_TOKEN_BITS, PROC_BITS+DURATION_BITS, PROC_BITS+TOKEN_BITS, NEW_TOKEN_BITS+CONN_BITS, PROC_BITS+CONN_BITS). Default value is 12.
- PACKET_BITS = 4+DATA_BITS
- BEATS = ceil(PACKET_BITS/IN_WIDTH)

Ports:
- clock_fast  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_data  in  IN_WIDTH  packet beat; MSB beat first
- in_valid  in  1  beat valid
- in_sync  in  1  framing restart
- in_ready  out  1  beat accepted when in_valid&&in_ready
- instruction  out  4  decoded opcode
- processor_id  out  PROC_BITS
- good_tokens_in, bad_tokens_in  out  NEW_TOKEN_BITS each
- prog_tokens  out  NEW_TOKEN_BITS
- connection_id  out  CONN_BITS
- prog_threshold  out  TOKEN_BITS
- prog_duration  out  DURATION_BITS
- instr_valid  out  1  decoded instruction held
- instr_ready  in  1  core consumes instruction
- evt_valid  in  1  core output_valid
- evt_proc  in  PROC_BITS  firing processor
- evt_startstop  in  2  start/stop code
- out_valid  out  1  FIFO head valid
- out_proc  out  PROC_BITS  FIFO head
- out_startstop  out  2  FIFO head
- out_ready  in  1  pops the FIFO head
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of entries in the FIFO
- clear_flags  in  1  clears the sticky flags
- overflow, bad_op  out  1 each  sticky flags

## Operation
Packet framing:
- The packet is right-aligned in BEATS·IN_WIDTH bits. Unused MSBs of the first beat are ignored.
- The opcode is packet[PACKET_BITS-1 -: 4]. data is packet[DATA_BITS-1:0].

FSM states: COLLECT and ISSUE.

COLLECT:
- in_ready=1.
- Each accepted beat shifts into the packet register and increments the beat counter.
- On the BEATS-th accepted beat, the counter returns to 0 and the opcode is checked:
  - Reserved opcode (0011, 01xx, 1000): the packet is dropped, bad_op←1, and the FSM stays in COLLECT.
  - Otherwise: the FSM goes to ISSUE.

ISSUE:
- in_ready=0 and instr_valid=1.
- All field outputs are held stable.
- When instr_ready=1, the FSM goes to COLLECT on the next cycle.

in_sync:
- In COLLECT, in_sync clears the beat counter and discards any partial packet.
- If in_valid is high in the same cycle, that beat is taken as beat 0.
- In ISSUE, in_sync has no effect.

Field slicing is combinational from the held packet and independent of the opcode:
- processor_id = data[DATA_BITS-1 -: PROC_BITS]
- prog_tokens = data[DATA_BITS-1 -: NEW_TOKEN_BITS]
- good_tokens_in = data[2·NEW_TOKEN_BITS-1 : NEW_TOKEN_BITS]
- bad_tokens_in = data[NEW_TOKEN_BITS-1:0]
- connection_id, prog_threshold and prog_duration are the LSB-aligned slices of data.

Valid opcodes 0000 (no-op) and 0010 (advance) are issued like any other opcode.

Event FIFO:
- Push condition: evt_valid && evt_startstop≠00.
- Pop condition: out_valid && out_ready.
- Full and push without pop: the event is dropped and overflow←1.
- Full with push and pop in the same cycle: both happen and count is unchanged.
- Empty with push: out_valid rises on the next cycle. There is no fall-through.
- Pointers wrap modulo FIFO_DEPTH.

Flags:
- bad_op and overflow are cleared by reset or clear_flags.
- If a set event and clear_flags occur in the same cycle, the set wins.

## Timing
Reset values:
- FSM=COLLECT, beat counter=0, packet register=0.
- in_ready=1, instr_valid=0, all field outputs=0, instruction=0000.
- out_valid=0, out_proc=0, out_startstop=00, fifo_count=0.
- overflow=0, bad_op=0.

Reset mid-packet discards the partial packet. Reset during ISSUE drops the held instruction.

Latency and throughput:
- instr_valid rises 1 cycle after the last beat is accepted.
- Minimum period is BEATS+1 cycles per packet.
- FIFO latency is push to out_valid in 1 cycle.

## Test plan
- Reset with all inputs 0 → in_ready=1; instr_valid, out_valid, fifo_count, overflow and bad_op all 0.
- Beats 0x1A, 0x53 (defaults), then instr_ready=0 for 3 cycles, then 1:
  - instr_valid=1 from the cycle after 0x53, with instruction=0001, processor_id=0xA, good_tokens_in=5, bad_tokens_in=3.
  - Fields stay stable and in_ready=0 while waiting.
  - in_ready=1 one cycle after the handshake.
- Beat 0x92, then in_sync together with beat 0x9F, then beat 0x40 → a single issue with instruction=1001, processor_id=0xF, prog_duration=0x40.
- Beats 0x30, 0x00 → no instr_valid and bad_op=1. A following clear_flags pulse → bad_op=0.
- With out_ready=0, push events (proc, ss) = (1,01), (2,10), (3,11), (4,00), (5,01), (6,01):
  - fifo_count=4 and overflow=1.
  - Draining yields 1, 2, 3, 5 in order, with out_startstop values preserved.
  - Refill to full, then push and pop in the same cycle → fifo_count stays 4 and overflow is unchanged.
- IN_WIDTH=4 build: beats 0xE, 0x3, 0x2, 0xA → instruction=1110, processor_id=3, connection_id=0x2A. A reset asserted after beat 2 → the next four beats form a fresh packet.

Source files
------------

// File: rtl/ttt_packet_frontend.sv
// rtl/ttt_packet_frontend.sv - beat-to-packet assembler, instruction decoder and start/stop event FIFO
// for the tick-tock-tokens core
module ttt_packet_frontend #(
   parameter int NUM_PROCESSORS  = 15,
   parameter int NUM_CONNECTIONS = 225,
   parameter int NEW_TOKEN_BITS  = 4,
   parameter int TOKEN_BITS      = 8,
   parameter int DURATION_BITS   = 8,
   parameter int IN_WIDTH        = 8,
   parameter int FIFO_DEPTH      = 4,
   localparam int PROC_BITS   = $clog2(NUM_PROCESSORS),
   localparam int CONN_BITS   = $clog2(NUM_CONNECTIONS),
   localparam int D_A         = PROC_BITS + 2 * NEW_TOKEN_BITS,
   localparam int D_B         = (PROC_BITS + DURATION_BITS > D_A) ? PROC_BITS + DURATION_BITS : D_A,
   localparam int D_C         = (PROC_BITS + TOKEN_BITS > D_B) ? PROC_BITS + TOKEN_BITS : D_B,
   localparam int D_D         = (NEW_TOKEN_BITS + CONN_BITS > D_C) ? NEW_TOKEN_BITS + CONN_BITS : D_C,
   localparam int DATA_BITS   = (PROC_BITS + CONN_BITS > D_D) ? PROC_BITS + CONN_BITS : D_D,
   localparam int PACKET_BITS = 4 + DATA_BITS,
   localparam int BEATS       = (PACKET_BITS + IN_WIDTH - 1) / IN_WIDTH,
   localparam int CNT_BITS    = (BEATS > 1) ? $clog2(BEATS) : 1,
   localparam int PTR_BITS    = $clog2(FIFO_DEPTH),
   localparam int FCNT_BITS   = PTR_BITS + 1
) (
   input  logic                      clock_fast,
   input  logic                      reset,
   input  logic [IN_WIDTH-1:0]       in_data,
   input  logic                      in_valid,
   input  logic                      in_sync,
   output logic                      in_ready,
   output logic [3:0]                instruction,
   output logic [PROC_BITS-1:0]      processor_id,
   output logic [NEW_TOKEN_BITS-1:0] good_tokens_in,
   output logic [NEW_TOKEN_BITS-1:0] bad_tokens_in,
   output logic [NEW_TOKEN_BITS-1:0] prog_tokens,
   output logic [CONN_BITS-1:0]      connection_id,
   output logic [TOKEN_BITS-1:0]     prog_threshold,
   output logic [DURATION_BITS-1:0]  prog_duration,
   output logic                      instr_valid,
   input  logic                      instr_ready,
   input  logic                      evt_valid,
   input  logic [PROC_BITS-1:0]      evt_proc,
   input  logic [1:0]                evt_startstop,
   output logic                      out_valid,
   output logic [PROC_BITS-1:0]      out_proc,
   output logic [1:0]                out_startstop,
   input  logic                      out_ready,
   output logic [FCNT_BITS-1:0]      fifo_count,
   input  logic                      clear_flags,
   output logic                      overflow,
   output logic                      bad_op
);

   typedef enum logic {COLLECT = 1'b0, ISSUE = 1'b1} state_t;

   state_t                   state_q, state_d;
   logic [CNT_BITS-1:0]      beat_q, beat_d, beat_base;
   logic [PACKET_BITS-1:0]   pkt_q, pkt_d, pkt_base, pkt_shift;
   logic [3:0]               opcode_new;
   logic                     reserved_new;
   logic                     bad_op_q, bad_op_d, bad_op_set;
   logic                     overflow_q, overflow_d;
   logic [PROC_BITS+1:0]     mem_q [FIFO_DEPTH];
   logic [PROC_BITS+1:0]     mem_d [FIFO_DEPTH];
   logic [PTR_BITS-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FCNT_BITS-1:0]     count_q, count_d;
   logic                     push, pop, full, push_ok;
   logic [PROC_BITS+1:0]     head;
   logic [DATA_BITS-1:0]     data;

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      pkt_d      = pkt_q;
      bad_op_set = 1'b0;
      // in_sync restarts framing; a beat in the same cycle becomes beat 0
      beat_base    = in_sync ? '0 : beat_q;
      pkt_base     = in_sync ? '0 : pkt_q;
      pkt_shift    = PACKET_BITS'({pkt_base, in_data});
      opcode_new   = pkt_shift[PACKET_BITS-1 -: 4];
      reserved_new = (opcode_new == 4'b0011) || (opcode_new[3:2] == 2'b01) || (opcode_new == 4'b1000);
      case (state_q)
         COLLECT: begin
            beat_d = beat_base;
            pkt_d  = pkt_base;
            if (in_valid) begin
               pkt_d = pkt_shift;
               if (beat_base == CNT_BITS'(BEATS - 1)) begin
                  beat_d = '0;
                  if (reserved_new) begin
                     bad_op_set = 1'b1;
                     pkt_d      = '0;
                  end else begin
                     state_d = ISSUE;
                  end
               end else begin
                  beat_d = beat_base + CNT_BITS'(1);
               end
            end
         end
         ISSUE: begin
            if (instr_ready) state_d = COLLECT;
         end
         default: state_d = COLLECT;
      endcase
      bad_op_d = bad_op_set ? 1'b1 : (clear_flags ? 1'b0 : bad_op_q);
   end

   always_comb begin
      push     = evt_valid && (evt_startstop != 2'b00);
      pop      = (count_q != '0) && out_ready;
      full     = (count_q == FCNT_BITS'(FIFO_DEPTH));
      // a pop in the same cycle frees the slot a full FIFO needs
      push_ok  = push && (!full || pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = {evt_proc, evt_startstop};
         wr_ptr_d        = wr_ptr_q + PTR_BITS'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
      if (push_ok && !pop) count_d = count_q + FCNT_BITS'(1);
      else if (!push_ok && pop) count_d = count_q - FCNT_BITS'(1);
      overflow_d = (push && !push_ok) ? 1'b1 : (clear_flags ? 1'b0 : overflow_q);
   end

   always_ff @(posedge clock_fast) begin
      if (reset) begin
         state_q    <= COLLECT;
         beat_q     <= '0;
         pkt_q      <= '0;
         bad_op_q   <= 1'b0;
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         pkt_q      <= pkt_d;
         bad_op_q   <= bad_op_d;
         overflow_q <= overflow_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         mem_q      <= mem_d;
      end
   end

   assign data           = pkt_q[DATA_BITS-1:0];
   assign instruction    = pkt_q[PACKET_BITS-1 -: 4];
   assign processor_id   = data[DATA_BITS-1 -: PROC_BITS];
   assign prog_tokens    = data[DATA_BITS-1 -: NEW_TOKEN_BITS];
   assign good_tokens_in = data[2*NEW_TOKEN_BITS-1 : NEW_TOKEN_BITS];
   assign bad_tokens_in  = data[NEW_TOKEN_BITS-1:0];
   assign connection_id  = data[CONN_BITS-1:0];
   assign prog_threshold = data[TOKEN_BITS-1:0];
   assign prog_duration  = data[DURATION_BITS-1:0];
   assign in_ready       = (state_q == COLLECT);
   assign instr_valid    = (state_q == ISSUE);

   assign head          = mem_q[rd_ptr_q];
   assign out_valid     = (count_q != '0);
   assign out_proc      = out_valid ? head[PROC_BITS+1:2] : '0;
   assign out_startstop = out_valid ? head[1:0] : 2'b00;
   assign fifo_count    = count_q;
   assign overflow      = overflow_q;
   assign bad_op        = bad_op_q;

endmodule

// File: tb/tb_ttt_packet_frontend.sv
// tb/tb_ttt_packet_frontend.sv - scoreboard bench for ttt_packet_frontend (IN_WIDTH 8 and 4 builds)
module tb_ttt_packet_frontend;

   typedef struct packed {
      logic [3:0] op;
      logic [3:0] proc;
      logic [3:0] good;
      logic [3:0] bad;
      logic [7:0] conn;
   } instr_t;

   typedef struct packed {
      logic [3:0] proc;
      logic [1:0] ss;
   } evt_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, instr_ready, evt_valid, out_ready, clear_flags;
   logic [3:0] evt_proc;
   logic [1:0] evt_ss;

   logic [7:0] in_data8;
   logic       in_valid8, in_sync8, in_ready8, instr_valid8, out_valid8, overflow8, bad_op8;
   logic [3:0] instruction8, proc8, good8, bad8, tok8, out_proc8;
   logic [7:0] conn8, thr8, dur8;
   logic [1:0] out_ss8;
   logic [2:0] fifo_count8;

   logic [3:0] in_data4;
   logic       in_valid4, in_sync4, in_ready4, instr_valid4, out_valid4, overflow4, bad_op4;
   logic [3:0] instruction4, proc4, good4, bad4, tok4, out_proc4;
   logic [7:0] conn4, thr4, dur4;
   logic [1:0] out_ss4;
   logic [2:0] fifo_count4;

   instr_t instr_q8[$];
   instr_t instr_q4[$];
   evt_t   evt_q[$];
   int     pass_cnt = 0;
   int     total_cnt = 0;

   ttt_packet_frontend dut8 (
      .clock_fast(clk), .reset(reset), .in_data(in_data8), .in_valid(in_valid8), .in_sync(in_sync8),
      .in_ready(in_ready8), .instruction(instruction8), .processor_id(proc8), .good_tokens_in(good8),
      .bad_tokens_in(bad8), .prog_tokens(tok8), .connection_id(conn8), .prog_threshold(thr8),
      .prog_duration(dur8), .instr_valid(instr_valid8), .instr_ready(instr_ready), .evt_valid(evt_valid),
      .evt_proc(evt_proc), .evt_startstop(evt_ss), .out_valid(out_valid8), .out_proc(out_proc8),
      .out_startstop(out_ss8), .out_ready(out_ready), .fifo_count(fifo_count8), .clear_flags(clear_flags),
      .overflow(overflow8), .bad_op(bad_op8)
   );

   ttt_packet_frontend #(.IN_WIDTH(4)) dut4 (
      .clock_fast(clk), .reset(reset), .in_data(in_data4), .in_valid(in_valid4), .in_sync(in_sync4),
      .in_ready(in_ready4), .instruction(instruction4), .processor_id(proc4), .good_tokens_in(good4),
      .bad_tokens_in(bad4), .prog_tokens(tok4), .connection_id(conn4), .prog_threshold(thr4),
      .prog_duration(dur4), .instr_valid(instr_valid4), .instr_ready(instr_ready), .evt_valid(evt_valid),
      .evt_proc(evt_proc), .evt_startstop(evt_ss), .out_valid(out_valid4), .out_proc(out_proc4),
      .out_startstop(out_ss4), .out_ready(out_ready), .fifo_count(fifo_count4), .clear_flags(clear_flags),
      .overflow(overflow4), .bad_op(bad_op4)
   );

   function automatic instr_t mk(input logic [3:0] op, input logic [3:0] proc, input logic [3:0] good,
                                 input logic [3:0] bad, input logic [7:0] conn);
      instr_t r;
      r.op = op; r.proc = proc; r.good = good; r.bad = bad; r.conn = conn;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send8(input logic [7:0] d, input logic s);
      in_data8 = d; in_valid8 = 1'b1; in_sync8 = s;
      step();
      in_data8 = '0; in_valid8 = 1'b0; in_sync8 = 1'b0;
   endtask

   task automatic send4(input logic [3:0] d);
      in_data4 = d; in_valid4 = 1'b1;
      step();
      in_data4 = '0; in_valid4 = 1'b0;
   endtask

   task automatic collect_instr8(input int budget);
      instr_t e;
      int n = 0;
      while (instr_valid8 !== 1'b1 && n < budget) begin step(); n++; end
      total_cnt++;
      if (instr_valid8 !== 1'b1 || instr_q8.size() == 0) begin
         $display("FAIL issue8_wait instr_valid=%b queued=%0d, required instr_valid=1 with a queued entry",
                  instr_valid8, instr_q8.size());
         return;
      end
      pass_cnt++;
      e = instr_q8.pop_front();
      total_cnt++;
      if ({instruction8, proc8, good8, bad8, conn8, dur8, tok8, thr8} !==
          {e.op, e.proc, e.good, e.bad, e.conn, e.conn, e.proc, e.conn})
         $display("FAIL issue8_fields got %h required %h",
                  {instruction8, proc8, good8, bad8, conn8, dur8, tok8, thr8},
                  {e.op, e.proc, e.good, e.bad, e.conn, e.conn, e.proc, e.conn});
      else pass_cnt++;
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      total_cnt++;
      if (instr_valid8 !== 1'b0 || in_ready8 !== 1'b1)
         $display("FAIL issue8_release instr_valid=%b in_ready=%b required 0/1", instr_valid8, in_ready8);
      else pass_cnt++;
   endtask

   task automatic collect_instr4(input int budget);
      instr_t e;
      int n = 0;
      while (instr_valid4 !== 1'b1 && n < budget) begin step(); n++; end
      total_cnt++;
      if (instr_valid4 !== 1'b1 || instr_q4.size() == 0) begin
         $display("FAIL issue4_wait instr_valid=%b queued=%0d, required instr_valid=1 with a queued entry",
                  instr_valid4, instr_q4.size());
         return;
      end
      pass_cnt++;
      e = instr_q4.pop_front();
      total_cnt++;
      if ({instruction4, proc4, good4, bad4, conn4, dur4} !== {e.op, e.proc, e.good, e.bad, e.conn, e.conn})
         $display("FAIL issue4_fields got %h required %h", {instruction4, proc4, good4, bad4, conn4, dur4},
                  {e.op, e.proc, e.good, e.bad, e.conn, e.conn});
      else pass_cnt++;
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      total_cnt++;
      if ({in_ready8, instr_valid8, out_valid8, fifo_count8, overflow8, bad_op8} !== 8'b1000_0000)
         $display("FAIL reset8 rdy/iv/ov/cnt/ovf/bad got %b required 10000000",
                  {in_ready8, instr_valid8, out_valid8, fifo_count8, overflow8, bad_op8});
      else pass_cnt++;
      total_cnt++;
      if ({instruction8, proc8, conn8, out_proc8, out_ss8} !== 22'h0)
         $display("FAIL reset8_fields got %h required 0", {instruction8, proc8, conn8, out_proc8, out_ss8});
      else pass_cnt++;
      total_cnt++;
      if ({in_ready4, instr_valid4, instruction4, conn4} !== {1'b1, 1'b0, 12'h0})
         $display("FAIL reset4 got %h required %h", {in_ready4, instr_valid4, instruction4, conn4},
                  {1'b1, 1'b0, 12'h0});
      else pass_cnt++;
   endtask

   task automatic test_issue();
      instr_ready = 1'b0;
      send8(8'h1A, 1'b0);
      send8(8'h53, 1'b0);
      instr_q8.push_back(mk(4'h1, 4'hA, 4'h5, 4'h3, 8'h53));
      for (int c = 0; c < 3; c++) begin
         total_cnt++;
         if ({instr_valid8, in_ready8, instruction8, proc8, good8, bad8} !== {1'b1, 1'b0, 16'h1A53})
            $display("FAIL issue_hold cycle %0d got %h required %h", c,
                     {instr_valid8, in_ready8, instruction8, proc8, good8, bad8}, {1'b1, 1'b0, 16'h1A53});
         else pass_cnt++;
         step();
      end
      collect_instr8(0);
   endtask

   task automatic test_sync();
      send8(8'h92, 1'b0);
      send8(8'h9F, 1'b1);
      total_cnt++;
      if ({instr_valid8, in_ready8} !== 2'b01)
         $display("FAIL sync_restart iv/rdy got %b required 01", {instr_valid8, in_ready8});
      else pass_cnt++;
      send8(8'h40, 1'b0);
      instr_q8.push_back(mk(4'h9, 4'hF, 4'h4, 4'h0, 8'h40));
      collect_instr8(0);
      step(); step();
      total_cnt++;
      if (instr_valid8 !== 1'b0) $display("FAIL sync_single_issue instr_valid got %b required 0", instr_valid8);
      else pass_cnt++;
   endtask

   task automatic test_bad_op();
      send8(8'h30, 1'b0);
      send8(8'h00, 1'b0);
      step();
      total_cnt++;
      if ({instr_valid8, bad_op8, in_ready8} !== 3'b011)
         $display("FAIL bad_op_drop iv/bad/rdy got %b required 011", {instr_valid8, bad_op8, in_ready8});
      else pass_cnt++;
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      total_cnt++;
      if (bad_op8 !== 1'b0) $display("FAIL bad_op_clear got %b required 0", bad_op8);
      else pass_cnt++;
      send8(8'h30, 1'b0);
      clear_flags = 1'b1;
      send8(8'h00, 1'b0);
      clear_flags = 1'b0;
      total_cnt++;
      if (bad_op8 !== 1'b1) $display("FAIL bad_op_set_wins got %b required 1", bad_op8);
      else pass_cnt++;
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
   endtask

   task automatic test_opcode_sweep();
      logic [3:0] op;
      logic       reserved;
      for (int k = 0; k < 16; k++) begin
         op = 4'(k);
         reserved = (op == 4'd3) || (op >= 4'd4 && op <= 4'd7) || (op == 4'd8);
         send8({op, 4'h1}, 1'b0);
         send8(8'h23, 1'b0);
         if (reserved) begin
            total_cnt++;
            if ({instr_valid8, bad_op8} !== 2'b01)
               $display("FAIL sweep_reserved op=%h iv/bad got %b required 01", op, {instr_valid8, bad_op8});
            else pass_cnt++;
            clear_flags = 1'b1;
            step();
            clear_flags = 1'b0;
         end else begin
            instr_q8.push_back(mk(op, 4'h1, 4'h2, 4'h3, 8'h23));
            total_cnt++;
            if (bad_op8 !== 1'b0) $display("FAIL sweep_valid op=%h bad_op got %b required 0", op, bad_op8);
            else pass_cnt++;
            collect_instr8(0);
         end
      end
   endtask

   task automatic test_back_to_back();
      instr_ready = 1'b1;
      send8(8'h1A, 1'b0);
      in_data8 = 8'h53; in_valid8 = 1'b1;
      step();
      total_cnt++;
      if ({instr_valid8, in_ready8, instruction8, proc8} !== {1'b1, 1'b0, 8'h1A})
         $display("FAIL b2b_first got %h required %h", {instr_valid8, in_ready8, instruction8, proc8},
                  {1'b1, 1'b0, 8'h1A});
      else pass_cnt++;
      in_data8 = 8'h2B;
      step();
      total_cnt++;
      if ({instr_valid8, in_ready8} !== 2'b01)
         $display("FAIL b2b_release iv/rdy got %b required 01", {instr_valid8, in_ready8});
      else pass_cnt++;
      step();
      in_data8 = 8'h64;
      step();
      in_valid8 = 1'b0; in_data8 = '0;
      instr_q8.push_back(mk(4'h2, 4'hB, 4'h6, 4'h4, 8'h64));
      collect_instr8(0);
   endtask

   task automatic test_fifo();
      evt_t tbl [6] = '{'{4'd1, 2'b01}, '{4'd2, 2'b10}, '{4'd3, 2'b11},
                        '{4'd4, 2'b00}, '{4'd5, 2'b01}, '{4'd6, 2'b01}};
      evt_t e;
      int   count_m = 0;
      logic ovf_m = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         evt_valid = 1'b1; evt_proc = tbl[i].proc; evt_ss = tbl[i].ss;
         if (tbl[i].ss != 2'b00) begin
            if (count_m < 4) begin evt_q.push_back(tbl[i]); count_m++; end
            else ovf_m = 1'b1;
         end
         step();
         total_cnt++;
         if ({fifo_count8, out_valid8} !== {3'(count_m), count_m != 0})
            $display("FAIL fifo_fill step %0d cnt/valid got %h required %h", i, {fifo_count8, out_valid8},
                     {3'(count_m), count_m != 0});
         else pass_cnt++;
      end
      evt_valid = 1'b0; evt_ss = 2'b00; evt_proc = '0;
      total_cnt++;
      if ({fifo_count8, overflow8} !== {3'd4, ovf_m})
         $display("FAIL fifo_overflow cnt/ovf got %h required %h", {fifo_count8, overflow8}, {3'd4, ovf_m});
      else pass_cnt++;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e = evt_q.pop_front();
         total_cnt++;
         if ({out_valid8, out_proc8, out_ss8} !== {1'b1, e})
            $display("FAIL fifo_drain %0d got %h required %h", i, {out_valid8, out_proc8, out_ss8}, {1'b1, e});
         else pass_cnt++;
         step();
      end
      out_ready = 1'b0;
      total_cnt++;
      if ({out_valid8, fifo_count8} !== 4'b0000)
         $display("FAIL fifo_empty valid/cnt got %b required 0000", {out_valid8, fifo_count8});
      else pass_cnt++;
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      total_cnt++;
      if (overflow8 !== 1'b0) $display("FAIL overflow_clear got %b required 0", overflow8);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         e.proc = 4'(7 + i); e.ss = 2'(1 + (i % 3));
         evt_valid = 1'b1; evt_proc = e.proc; evt_ss = e.ss;
         evt_q.push_back(e);
         step();
      end
      e.proc = 4'd11; e.ss = 2'b11;
      evt_proc = e.proc; evt_ss = e.ss; out_ready = 1'b1;
      evt_q.push_back(e);
      e = evt_q.pop_front();
      total_cnt++;
      if ({fifo_count8, out_proc8, out_ss8} !== {3'd4, e})
         $display("FAIL fifo_full_head got %h required %h", {fifo_count8, out_proc8, out_ss8}, {3'd4, e});
      else pass_cnt++;
      step();
      evt_valid = 1'b0; evt_ss = 2'b00; evt_proc = '0; out_ready = 1'b0;
      total_cnt++;
      if ({fifo_count8, overflow8} !== {3'd4, 1'b0})
         $display("FAIL fifo_push_pop_full cnt/ovf got %h required 8", {fifo_count8, overflow8});
      else pass_cnt++;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e = evt_q.pop_front();
         total_cnt++;
         if ({out_valid8, out_proc8, out_ss8} !== {1'b1, e})
            $display("FAIL fifo_drain2 %0d got %h required %h", i, {out_valid8, out_proc8, out_ss8}, {1'b1, e});
         else pass_cnt++;
         step();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_width4();
      send4(4'hE); send4(4'h3); send4(4'h2); send4(4'hA);
      instr_q4.push_back(mk(4'hE, 4'h3, 4'h2, 4'hA, 8'h2A));
      collect_instr4(0);
      send4(4'h5); send4(4'h6);
      reset = 1'b1;
      step();
      reset = 1'b0;
      send4(4'h2); send4(4'h7); send4(4'h1);
      total_cnt++;
      if ({instr_valid4, in_ready4} !== 2'b01)
         $display("FAIL w4_after_reset iv/rdy got %b required 01", {instr_valid4, in_ready4});
      else pass_cnt++;
      send4(4'hC);
      instr_q4.push_back(mk(4'h2, 4'h7, 4'h1, 4'hC, 8'h1C));
      collect_instr4(0);
   endtask

   task automatic test_reset_issue();
      send8(8'h1A, 1'b0);
      send8(8'h53, 1'b0);
      total_cnt++;
      if (instr_valid8 !== 1'b1) $display("FAIL rst_issue_pre instr_valid got %b required 1", instr_valid8);
      else pass_cnt++;
      reset = 1'b1;
      step();
      reset = 1'b0;
      total_cnt++;
      if ({instr_valid8, in_ready8, instruction8, proc8} !== {1'b0, 1'b1, 8'h00})
         $display("FAIL rst_issue_drop got %h required %h", {instr_valid8, in_ready8, instruction8, proc8},
                  {1'b0, 1'b1, 8'h00});
      else pass_cnt++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; instr_ready = 1'b0; evt_valid = 1'b0; out_ready = 1'b0; clear_flags = 1'b0;
      evt_proc = '0; evt_ss = '0;
      in_data8 = '0; in_valid8 = 1'b0; in_sync8 = 1'b0;
      in_data4 = '0; in_valid4 = 1'b0; in_sync4 = 1'b0;
      test_reset();
      test_issue();
      test_sync();
      test_bad_op();
      test_opcode_sweep();
      test_back_to_back();
      test_fifo();
      test_width4();
      test_reset_issue();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
